// File: rtl/operand_skew_feeder.sv
// rtl/operand_skew_feeder.sv - streams one operand tile into the array edge with diagonal lane skew
// Optional FEEDER_STALL_EN adds a stall input that freezes the block and parks in-flight read data.
`timescale 1ns/1ps
module operand_skew_feeder #(
   parameter int DW    = 16,
   parameter int LANES = 4,
   parameter int CW    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef FEEDER_STALL_EN
   input  logic                  stall,
`endif
   input  logic                  start,
   input  logic [CW-1:0]         base_col,
   input  logic [3:0]            len,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [CW-1:0]         rd_col,
   input  logic [LANES*DW-1:0]   rd_data,
   output logic [LANES*DW-1:0]   lane_data,
   output logic [LANES-1:0]      lane_valid
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        col_q;
   logic [3:0]           cnt_q, len_q;
   // v_q[0]: a read is returning this cycle; v_q[r+1]: lane r output is valid
   logic [LANES:0]       v_q;
   logic                 adv;
   logic [LANES*DW-1:0]  src;

`ifdef FEEDER_STALL_EN
   logic                 hold_v;
   logic [LANES*DW-1:0]  hold_q;

   assign adv = !stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_v <= 1'b0;
         hold_q <= '0;
      end else if (stall) begin
         if (v_q[0] && !hold_v) begin
            hold_v <= 1'b1;
            hold_q <= rd_data;
         end
      end else begin
         hold_v <= 1'b0;
      end
   end

   assign src = hold_v ? hold_q : rd_data;
`else
   assign adv = 1'b1;
   assign src = rd_data;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= IDLE;
      else if (adv)
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (len != 4'd0) ? READ : DONE;
         READ:    if (cnt_q == len_q - 4'd1) state_d = DRAIN;
         // rd_en is low here, so the pipeline is empty next cycle once only output stages hold data
         DRAIN:   if (v_q[LANES-1:0] == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE) && adv;
      rd_en  = (state_q == READ) && adv;
      rd_col = (state_q == READ) ? col_q : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
         v_q   <= '0;
      end else if (adv) begin
         if (state_q == IDLE && start) begin
            col_q <= base_col;
            len_q <= len;
            cnt_q <= '0;
         end else if (state_q == READ) begin
            col_q <= col_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
         end
         v_q <= {v_q[LANES-1:0], rd_en};
      end
   end

   for (genvar r = 0; r < LANES; r++) begin : g_lane
      logic [(r+1)*DW-1:0] sh_q;
      logic [DW-1:0]       cap;

      assign cap = v_q[0] ? src[r*DW +: DW] : '0;

      if (r == 0) begin : g_first
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               sh_q <= '0;
            else if (adv)
               sh_q <= cap;
         end
      end else begin : g_chain
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               sh_q <= '0;
            else if (adv)
               sh_q <= {sh_q[r*DW-1:0], cap};
         end
      end

      assign lane_data[r*DW +: DW] = adv ? sh_q[r*DW +: DW] : '0;
   end

   assign lane_valid = adv ? v_q[LANES:1] : '0;

endmodule
